serial_cla_sequencer: RTL
=========================

Name: serial_cla_sequencer

Overview:
Multi-cycle add/subtract engine that time-shares one 4-bit carry-lookahead slice across a WIDTH-bit operand, one nibble per clock, LSB nibble first.
The nibble carry is registered between cycles.
Sits beside the ALU datapath wherever a wide add is needed but only one 4-bit CLA slice is affordable.
Start/Busy/Done handshake toward the issuing controller.

Parameters:
WIDTH, 16, operand/result width in bits; multiple of 4, >= 4
NIBBLES, WIDTH/4, derived slice-cycle count; localparam, not overridable

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  request; sampled only in IDLE
Sub  input  1  0 = A+B, 1 = A-B; sampled with Start
A  input  WIDTH  operand A; sampled with Start
B  input  WIDTH  operand B; sampled with Start
Busy  output  1  high while in RUN
Done  output  1  one-cycle pulse; Sum/Cout valid from this cycle
Sum  output  WIDTH  registered result; held until next completion
Cout  output  1  carry out of MSB nibble; for Sub, 1 = no borrow

Behaviour:
- Reset (async, any state):
  - state to IDLE.
  - Busy=0, Done=0, Sum=0, Cout=0.
  - Internal operand, carry and index registers cleared.
- States and transitions:
  - IDLE: on Start=1 at an edge:
    - latch A.
    - latch B, or ~B when Sub=1.
    - carry register = Sub.
    - nibble index = 0.
    - go to RUN.
  - RUN: each edge:
    - slice adds opA[4i+3:4i] + opB[4i+3:4i] + carry.
    - the 4-bit sum is written into nibble i of an internal result register.
    - carry register = slice cout.
    - i increments.
    - After the edge that processes i = NIBBLES-1: copy internal result to Sum, final carry to Cout, go to DONE.
  - DONE: Done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
- Latency: if Start is accepted at edge k, Busy is high for cycles k+1 .. k+NIBBLES and Done is high in cycle k+NIBBLES+1.
  - WIDTH=16: Done is high 5 edges after acceptance.
  - Throughput: one operation per NIBBLES+2 cycles.
- Start is ignored in RUN and DONE; there is no queuing. A/B/Sub changes after acceptance have no effect.
- Sum/Cout change only on the RUN->DONE edge. Intermediate nibbles are never visible on Sum.
- WIDTH=4: RUN lasts one cycle.
- Reset mid-RUN: the operation is abandoned. Done does not assert, and Sum returns to 0 (not the previous result).
- Arithmetic is modulo 2^WIDTH. Subtraction is two's complement via inverted B with carry-in 1.

Optional Feature:
- Macro: SERIAL_CLA_OVF_EN.
- When defined:
  - Adds output port Ovf (1 bit), the registered signed overflow.
  - Ovf = carry into MSB XOR carry out of MSB.
  - Captured on the same edge as Sum; reset value 0.
  - Carry into the MSB is taken from the slice's internal bit-3 carry in the last RUN cycle, recomputed as opA[MSB]^opB'[MSB]^Sum[MSB].
- When undefined: no Ovf port and no related logic. Other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t
  - localparam NIBBLE_W = 4
- Sub-module: one instance of the existing fourbitCLAdder as the slice.
  - Its PG/GG outputs are left unconnected.
  - No other sub-modules; FSM, operand registers and index counter are inline.

Test Plan:
- Basic add: A=0x1234, B=0x4321, Sub=0, Start pulse -> Busy high 4 cycles; Done at edge k+5; Sum=0x5555, Cout=0.
- Full carry ripple across nibbles: A=0xFFFF, B=0x0001 -> Sum=0x0000, Cout=1; with OVF_EN, Ovf=0.
- Subtract with borrow: A=0x0005, B=0x0007, Sub=1 -> Sum=0xFFFE, Cout=0. Then A=0x0009, B=0x0003, Sub=1 -> Sum=0x0006, Cout=1.
- Start while busy:
  - Start A=0x0001, B=0x0001.
  - Pulse Start again at cycle k+2 with A=0xAAAA.
  - Required: second Start ignored; Sum=0x0002; exactly one Done pulse.
- Reset mid-RUN:
  - Prior result Sum=0x5555.
  - Start a new op, assert Reset asynchronously at k+2 (between edges).
  - Required: Busy=0 and Sum=0 immediately; no Done; a subsequent op completes normally.
- Overflow (OVF_EN): A=0x7FFF, B=0x0001 -> Sum=0x8000, Ovf=1, Cout=0. A=0x8000, B=0x8000 -> Sum=0x0000, Ovf=1, Cout=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and slice width.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

    localparam int NIBBLE_W = 4;

endpackage : alu_pkg

// File: rtl/serial_cla_sequencer_slice.sv
// Four-bit carry-lookahead adder slice, time-shared by serial_cla_sequencer.
// Carries are produced by lookahead equations rather than by rippling.
// pg/gg are the group propagate/generate outputs for cascading.
module fourbitCLAdder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       pg,
    output logic       gg
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Lookahead carry equations expanded for each bit position
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
        pg   = &p;
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule : fourbitCLAdder

// File: rtl/serial_cla_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract using one 4-bit CLA slice, one nibble
// per clock, LSB nibble first, with the inter-nibble carry registered.
// Optional macro SERIAL_CLA_OVF_EN adds the registered signed-overflow output Ovf.
module serial_cla_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_CLA_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    seq_state_t          state;
    seq_state_t          next_state;
    logic [WIDTH-1:0]    op_a;
    logic [WIDTH-1:0]    op_b;
    logic [WIDTH-1:0]    result;
    logic [WIDTH-1:0]    next_result;
    logic                carry;
    logic [IDX_W-1:0]    idx;
    logic                last_nibble;
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;

    fourbitCLAdder u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout),
        .pg   (),
        .gg   ()
    );

    // Select the current nibble of each operand and merge the slice sum into the result
    always_comb begin
        a_nib       = op_a[{idx, 2'b00} +: NIBBLE_W];
        b_nib       = op_b[{idx, 2'b00} +: NIBBLE_W];
        last_nibble = (idx == IDX_W'(NIBBLES - 1));
        next_result = result;
        next_result[{idx, 2'b00} +: NIBBLE_W] = slice_sum;
    end

`ifdef SERIAL_CLA_OVF_EN
    logic carry_into_msb;

    // Recover the carry into the top bit from the slice's bit-3 inputs and sum
    always_comb begin
        carry_into_msb = a_nib[3] ^ b_nib[3] ^ slice_sum[3];
    end
`endif

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and handshake outputs decoded from state
    always_comb begin
        next_state = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (last_nibble) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                Done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, per-nibble accumulation, and result publication on the last nibble
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            Sum    <= '0;
            Cout   <= 1'b0;
`ifdef SERIAL_CLA_OVF_EN
            Ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        op_a  <= A;
                        op_b  <= Sub ? ~B : B;
                        carry <= Sub;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    result <= next_result;
                    carry  <= slice_cout;
                    idx    <= idx + IDX_W'(1);
                    if (last_nibble) begin
                        Sum  <= next_result;
                        Cout <= slice_cout;
`ifdef SERIAL_CLA_OVF_EN
                        Ovf  <= carry_into_msb ^ slice_cout;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : serial_cla_sequencer
